// File: rtl/issue_queue_pkg.sv
// rtl/issue_queue_pkg.sv - default sizing and slot layout shared by the issue queue and its users
package issue_queue_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_TAG_W  = 5;

    typedef struct packed {
        logic                  valid;
        logic [DEF_TAG_W-1:0]  rd_tag;
        logic [DEF_TAG_W-1:0]  rs_tag;
        logic [DEF_TAG_W-1:0]  rt_tag;
        logic [DEF_DATA_W-1:0] rs_data;
        logic [DEF_DATA_W-1:0] rt_data;
        logic                  rs_val;
        logic                  rt_val;
    } iq_entry_t;

endpackage

// File: rtl/issue_queue_entry.sv
// rtl/issue_queue_entry.sv - one collapsing-queue slot; ISSUEQ_DISPATCH_BYPASS_EN adds dispatch-time CDB capture
module issue_queue_entry
    import issue_queue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              Shift,
    input  logic              Load,
    input  logic              Up_Valid,
    input  logic              Up_Rs_Val,
    input  logic              Up_Rt_Val,
    input  logic [TAG_W-1:0]  Up_Rd_Tag,
    input  logic [TAG_W-1:0]  Up_Rs_Tag,
    input  logic [TAG_W-1:0]  Up_Rt_Tag,
    input  logic [DATA_W-1:0] Up_Rs_Data,
    input  logic [DATA_W-1:0] Up_Rt_Data,
    input  logic [TAG_W-1:0]  Disp_Rd_Tag,
    input  logic [TAG_W-1:0]  Disp_Rs_Tag,
    input  logic [TAG_W-1:0]  Disp_Rt_Tag,
    input  logic [DATA_W-1:0] Disp_Rs_Data,
    input  logic [DATA_W-1:0] Disp_Rt_Data,
    input  logic              Disp_Rs_Data_Val,
    input  logic              Disp_Rt_Data_Val,
    input  logic              CDB_Valid,
    input  logic [TAG_W-1:0]  CDB_Tag,
    input  logic [DATA_W-1:0] CDB_Data,
    output logic              Valid,
    output logic              Rs_Val,
    output logic              Rt_Val,
    output logic [TAG_W-1:0]  Rd_Tag,
    output logic [TAG_W-1:0]  Rs_Tag,
    output logic [TAG_W-1:0]  Rt_Tag,
    output logic [DATA_W-1:0] Rs_Data,
    output logic [DATA_W-1:0] Rt_Data
);

    logic              nxt_valid, nxt_rs_val, nxt_rt_val;
    logic [TAG_W-1:0]  nxt_rd_tag, nxt_rs_tag, nxt_rt_tag;
    logic [DATA_W-1:0] nxt_rs_data, nxt_rt_data;

    // Wakeup is applied to whichever contents land here, so a capture follows a shift.
    always_comb begin
        nxt_valid   = Shift ? Up_Valid   : Valid;
        nxt_rs_val  = Shift ? Up_Rs_Val  : Rs_Val;
        nxt_rt_val  = Shift ? Up_Rt_Val  : Rt_Val;
        nxt_rd_tag  = Shift ? Up_Rd_Tag  : Rd_Tag;
        nxt_rs_tag  = Shift ? Up_Rs_Tag  : Rs_Tag;
        nxt_rt_tag  = Shift ? Up_Rt_Tag  : Rt_Tag;
        nxt_rs_data = Shift ? Up_Rs_Data : Rs_Data;
        nxt_rt_data = Shift ? Up_Rt_Data : Rt_Data;

        if (nxt_valid && !nxt_rs_val && CDB_Valid && (CDB_Tag == nxt_rs_tag)) begin
            nxt_rs_val  = 1'b1;
            nxt_rs_data = CDB_Data;
        end
        if (nxt_valid && !nxt_rt_val && CDB_Valid && (CDB_Tag == nxt_rt_tag)) begin
            nxt_rt_val  = 1'b1;
            nxt_rt_data = CDB_Data;
        end

        if (Load) begin
            nxt_valid   = 1'b1;
            nxt_rd_tag  = Disp_Rd_Tag;
            nxt_rs_tag  = Disp_Rs_Tag;
            nxt_rt_tag  = Disp_Rt_Tag;
            nxt_rs_val  = Disp_Rs_Data_Val;
            nxt_rt_val  = Disp_Rt_Data_Val;
            nxt_rs_data = Disp_Rs_Data;
            nxt_rt_data = Disp_Rt_Data;
`ifdef ISSUEQ_DISPATCH_BYPASS_EN
            if (!Disp_Rs_Data_Val && CDB_Valid && (CDB_Tag == Disp_Rs_Tag)) begin
                nxt_rs_val  = 1'b1;
                nxt_rs_data = CDB_Data;
            end
            if (!Disp_Rt_Data_Val && CDB_Valid && (CDB_Tag == Disp_Rt_Tag)) begin
                nxt_rt_val  = 1'b1;
                nxt_rt_data = CDB_Data;
            end
`else
            // A broadcast coinciding with dispatch is not seen by the new entry.
`endif
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Valid   <= 1'b0;
            Rs_Val  <= 1'b0;
            Rt_Val  <= 1'b0;
            Rd_Tag  <= '0;
            Rs_Tag  <= '0;
            Rt_Tag  <= '0;
            Rs_Data <= '0;
            Rt_Data <= '0;
        end else if (Flush) begin
            Valid   <= 1'b0;
            Rs_Val  <= 1'b0;
            Rt_Val  <= 1'b0;
        end else begin
            Valid   <= nxt_valid;
            Rs_Val  <= nxt_rs_val;
            Rt_Val  <= nxt_rt_val;
            Rd_Tag  <= nxt_rd_tag;
            Rs_Tag  <= nxt_rs_tag;
            Rt_Tag  <= nxt_rt_tag;
            Rs_Data <= nxt_rs_data;
            Rt_Data <= nxt_rt_data;
        end
    end

endmodule

// File: rtl/issue_queue_gen.sv
// rtl/issue_queue_gen.sv - collapsing in-order-priority issue queue; ISSUEQ_DISPATCH_BYPASS_EN selects dispatch bypass
module issue_queue_gen
    import issue_queue_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Dispatch_Enable,
    input  logic [TAG_W-1:0]           Dispatch_Rd_Tag,
    input  logic [TAG_W-1:0]           Dispatch_Rs_Tag,
    input  logic [TAG_W-1:0]           Dispatch_Rt_Tag,
    input  logic [DATA_W-1:0]          Dispatch_Rs_Data,
    input  logic [DATA_W-1:0]          Dispatch_Rt_Data,
    input  logic                       Dispatch_Rs_Data_Val,
    input  logic                       Dispatch_Rt_Data_Val,
    input  logic                       CDB_Valid,
    input  logic [TAG_W-1:0]           CDB_Tag,
    input  logic [DATA_W-1:0]          CDB_Data,
    input  logic                       Issueblk_Issue,
    input  logic                       RB_Flush_Valid,
    output logic                       IssueQue_Ready,
    output logic [DATA_W-1:0]          IssueQue_Rs_Data,
    output logic [DATA_W-1:0]          IssueQue_Rt_Data,
    output logic [TAG_W-1:0]           IssueQue_Rd_Tag,
    output logic                       IssueQue_Full,
    output logic [$clog2(DEPTH+1)-1:0] IssueQue_Count
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int SEL_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid, rs_val, rt_val, ready, shift, load;
    logic [DEPTH-1:0]  up_valid, up_rs_val, up_rt_val;
    logic [TAG_W-1:0]  rd_tag [DEPTH];
    logic [TAG_W-1:0]  rs_tag [DEPTH];
    logic [TAG_W-1:0]  rt_tag [DEPTH];
    logic [TAG_W-1:0]  up_rd_tag [DEPTH];
    logic [TAG_W-1:0]  up_rs_tag [DEPTH];
    logic [TAG_W-1:0]  up_rt_tag [DEPTH];
    logic [DATA_W-1:0] rs_data [DEPTH];
    logic [DATA_W-1:0] rt_data [DEPTH];
    logic [DATA_W-1:0] up_rs_data [DEPTH];
    logic [DATA_W-1:0] up_rt_data [DEPTH];

    logic [SEL_W-1:0]  sel;
    logic              any_ready, issue, accept;
    logic [CNT_W-1:0]  count, wr_idx;

    assign ready = valid & rs_val & rt_val;

    // Scanning from the top leaves the lowest ready index in sel; 0 when none is ready.
    always_comb begin
        sel       = '0;
        any_ready = 1'b0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (ready[i]) begin
                sel       = SEL_W'(i);
                any_ready = 1'b1;
            end
        end
    end

    assign issue  = Issueblk_Issue & any_ready;
    assign IssueQue_Full = (count == CNT_W'(DEPTH)) & ~issue;
    assign accept = Dispatch_Enable & ~IssueQue_Full;
    assign wr_idx = count - CNT_W'(issue);

    assign IssueQue_Ready   = any_ready;
    assign IssueQue_Rd_Tag  = rd_tag[sel];
    assign IssueQue_Rs_Data = rs_data[sel];
    assign IssueQue_Rt_Data = rt_data[sel];
    assign IssueQue_Count   = count;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign shift[g] = issue & (SEL_W'(g) >= sel);
        assign load[g]  = accept & (wr_idx == CNT_W'(g));

        if (g < DEPTH-1) begin : g_up
            assign up_valid[g]   = valid[g+1];
            assign up_rs_val[g]  = rs_val[g+1];
            assign up_rt_val[g]  = rt_val[g+1];
            assign up_rd_tag[g]  = rd_tag[g+1];
            assign up_rs_tag[g]  = rs_tag[g+1];
            assign up_rt_tag[g]  = rt_tag[g+1];
            assign up_rs_data[g] = rs_data[g+1];
            assign up_rt_data[g] = rt_data[g+1];
        end else begin : g_top
            assign up_valid[g]   = 1'b0;
            assign up_rs_val[g]  = 1'b0;
            assign up_rt_val[g]  = 1'b0;
            assign up_rd_tag[g]  = '0;
            assign up_rs_tag[g]  = '0;
            assign up_rt_tag[g]  = '0;
            assign up_rs_data[g] = '0;
            assign up_rt_data[g] = '0;
        end

        issue_queue_entry #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W)
        ) u_entry (
            .Clk              (Clk),
            .Rst              (Rst),
            .Flush            (RB_Flush_Valid),
            .Shift            (shift[g]),
            .Load             (load[g]),
            .Up_Valid         (up_valid[g]),
            .Up_Rs_Val        (up_rs_val[g]),
            .Up_Rt_Val        (up_rt_val[g]),
            .Up_Rd_Tag        (up_rd_tag[g]),
            .Up_Rs_Tag        (up_rs_tag[g]),
            .Up_Rt_Tag        (up_rt_tag[g]),
            .Up_Rs_Data       (up_rs_data[g]),
            .Up_Rt_Data       (up_rt_data[g]),
            .Disp_Rd_Tag      (Dispatch_Rd_Tag),
            .Disp_Rs_Tag      (Dispatch_Rs_Tag),
            .Disp_Rt_Tag      (Dispatch_Rt_Tag),
            .Disp_Rs_Data     (Dispatch_Rs_Data),
            .Disp_Rt_Data     (Dispatch_Rt_Data),
            .Disp_Rs_Data_Val (Dispatch_Rs_Data_Val),
            .Disp_Rt_Data_Val (Dispatch_Rt_Data_Val),
            .CDB_Valid        (CDB_Valid),
            .CDB_Tag          (CDB_Tag),
            .CDB_Data         (CDB_Data),
            .Valid            (valid[g]),
            .Rs_Val           (rs_val[g]),
            .Rt_Val           (rt_val[g]),
            .Rd_Tag           (rd_tag[g]),
            .Rs_Tag           (rs_tag[g]),
            .Rt_Tag           (rt_tag[g]),
            .Rs_Data          (rs_data[g]),
            .Rt_Data          (rt_data[g])
        );
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count <= '0;
        end else if (RB_Flush_Valid) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(accept) - CNT_W'(issue);
        end
    end

endmodule

// File: tb/tb_issue_queue_gen.sv
// tb/tb_issue_queue_gen.sv - self-checking bench for issue_queue_gen
`timescale 1ns/1ps
module tb_issue_queue_gen;
    import issue_queue_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 5;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              Clk = 1'b0;
    logic              Rst;
    logic              Dispatch_Enable;
    logic [TAG_W-1:0]  Dispatch_Rd_Tag, Dispatch_Rs_Tag, Dispatch_Rt_Tag;
    logic [DATA_W-1:0] Dispatch_Rs_Data, Dispatch_Rt_Data;
    logic              Dispatch_Rs_Data_Val, Dispatch_Rt_Data_Val;
    logic              CDB_Valid;
    logic [TAG_W-1:0]  CDB_Tag;
    logic [DATA_W-1:0] CDB_Data;
    logic              Issueblk_Issue;
    logic              RB_Flush_Valid;
    logic              IssueQue_Ready;
    logic [DATA_W-1:0] IssueQue_Rs_Data, IssueQue_Rt_Data;
    logic [TAG_W-1:0]  IssueQue_Rd_Tag;
    logic              IssueQue_Full;
    logic [CNT_W-1:0]  IssueQue_Count;

    always #5 Clk = ~Clk;

    issue_queue_gen #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .Clk                  (Clk),
        .Rst                  (Rst),
        .Dispatch_Enable      (Dispatch_Enable),
        .Dispatch_Rd_Tag      (Dispatch_Rd_Tag),
        .Dispatch_Rs_Tag      (Dispatch_Rs_Tag),
        .Dispatch_Rt_Tag      (Dispatch_Rt_Tag),
        .Dispatch_Rs_Data     (Dispatch_Rs_Data),
        .Dispatch_Rt_Data     (Dispatch_Rt_Data),
        .Dispatch_Rs_Data_Val (Dispatch_Rs_Data_Val),
        .Dispatch_Rt_Data_Val (Dispatch_Rt_Data_Val),
        .CDB_Valid            (CDB_Valid),
        .CDB_Tag              (CDB_Tag),
        .CDB_Data             (CDB_Data),
        .Issueblk_Issue       (Issueblk_Issue),
        .RB_Flush_Valid       (RB_Flush_Valid),
        .IssueQue_Ready       (IssueQue_Ready),
        .IssueQue_Rs_Data     (IssueQue_Rs_Data),
        .IssueQue_Rt_Data     (IssueQue_Rt_Data),
        .IssueQue_Rd_Tag      (IssueQue_Rd_Tag),
        .IssueQue_Full        (IssueQue_Full),
        .IssueQue_Count       (IssueQue_Count)
    );

    int n_total = 0;
    int n_pass  = 0;
    iq_entry_t sb[$];

    typedef struct {
        logic             disp;
        logic [TAG_W-1:0] tag;
        logic             issue;
        logic             exp_ready;
        logic             exp_full;
        logic [CNT_W-1:0] exp_count;
    } vec_t;
    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle();
        Dispatch_Enable      = 1'b0;
        Dispatch_Rd_Tag      = '0;
        Dispatch_Rs_Tag      = '0;
        Dispatch_Rt_Tag      = '0;
        Dispatch_Rs_Data     = '0;
        Dispatch_Rt_Data     = '0;
        Dispatch_Rs_Data_Val = 1'b0;
        Dispatch_Rt_Data_Val = 1'b0;
        CDB_Valid            = 1'b0;
        CDB_Tag              = '0;
        CDB_Data             = '0;
        Issueblk_Issue       = 1'b0;
        RB_Flush_Valid       = 1'b0;
    endtask

    task automatic disp(input logic [TAG_W-1:0] rd, input logic [TAG_W-1:0] rs_t, input logic rs_v,
                        input logic [DATA_W-1:0] rs_d, input logic [TAG_W-1:0] rt_t, input logic rt_v,
                        input logic [DATA_W-1:0] rt_d);
        Dispatch_Enable      = 1'b1;
        Dispatch_Rd_Tag      = rd;
        Dispatch_Rs_Tag      = rs_t;
        Dispatch_Rs_Data_Val = rs_v;
        Dispatch_Rs_Data     = rs_d;
        Dispatch_Rt_Tag      = rt_t;
        Dispatch_Rt_Data_Val = rt_v;
        Dispatch_Rt_Data     = rt_d;
    endtask

    task automatic push(input logic [TAG_W-1:0] rd, input logic [DATA_W-1:0] rs_d, input logic [DATA_W-1:0] rt_d);
        iq_entry_t e;
        e = '0;
        e.rd_tag  = rd;
        e.rs_data = rs_d;
        e.rt_data = rt_d;
        sb.push_back(e);
    endtask

    // Inputs are driven just after a falling edge; one call spans the following rising edge.
    task automatic tick();
        iq_entry_t e;
        #1;
        if (Issueblk_Issue && IssueQue_Ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow: issued tag 0x%0h, expected no issue", IssueQue_Rd_Tag);
            end else begin
                e = sb.pop_front();
                check("issue_tag", IssueQue_Rd_Tag, e.rd_tag);
                check("issue_rs", IssueQue_Rs_Data, e.rs_data);
                check("issue_rt", IssueQue_Rt_Data, e.rt_data);
            end
        end
        @(negedge Clk);
        idle();
    endtask

    function automatic logic [DATA_W-1:0] rs_of(input logic [TAG_W-1:0] t);
        return 16'hA000 | DATA_W'(t);
    endfunction

    function automatic logic [DATA_W-1:0] rt_of(input logic [TAG_W-1:0] t);
        return 16'hB000 | DATA_W'(t);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 3'd1};
        vt[1] = '{1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 3'd2};
        vt[2] = '{1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 3'd3};
        vt[3] = '{1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 3'd4};
        vt[4] = '{1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 3'd4};
        vt[5] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 3'd3};
        vt[6] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 3'd2};
        vt[7] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 3'd1};
        vt[8] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 3'd0};
        vt[9] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0};

        Rst = 1'b1;
        idle();
        @(negedge Clk);
        @(negedge Clk);
        check("rst_count", IssueQue_Count, 0);
        check("rst_ready", IssueQue_Ready, 0);
        check("rst_full", IssueQue_Full, 0);
        check("rst_rd_tag", IssueQue_Rd_Tag, 0);
        check("rst_rs_data", IssueQue_Rs_Data, 0);
        check("rst_rt_data", IssueQue_Rt_Data, 0);
        Rst = 1'b0;
        @(negedge Clk);

        // fill, overflow drop, in-order drain, issue with nothing ready
        for (int i = 0; i < 10; i++) begin
            if (vt[i].disp) disp(vt[i].tag, 5'd0, 1'b1, rs_of(vt[i].tag), 5'd0, 1'b1, rt_of(vt[i].tag));
            Issueblk_Issue = vt[i].issue;
            #1;
            check($sformatf("vec%0d_ready", i), IssueQue_Ready, vt[i].exp_ready);
            check($sformatf("vec%0d_full", i), IssueQue_Full, vt[i].exp_full);
            if (vt[i].disp && !vt[i].exp_full) push(vt[i].tag, rs_of(vt[i].tag), rt_of(vt[i].tag));
            tick();
            check($sformatf("vec%0d_count", i), IssueQue_Count, vt[i].exp_count);
        end

        // full queue with simultaneous issue accepts dispatch into the last slot
        for (int t = 1; t <= 4; t++) begin
            disp(5'(t), 5'd0, 1'b1, rs_of(5'(t)), 5'd0, 1'b1, rt_of(5'(t)));
            push(5'(t), rs_of(5'(t)), rt_of(5'(t)));
            tick();
        end
        check("full_count", IssueQue_Count, 4);
        disp(5'd6, 5'd0, 1'b1, rs_of(5'd6), 5'd0, 1'b1, rt_of(5'd6));
        Issueblk_Issue = 1'b1;
        #1;
        check("full_issue_full", IssueQue_Full, 0);
        push(5'd6, rs_of(5'd6), rt_of(5'd6));
        tick();
        check("full_issue_count", IssueQue_Count, 4);
        for (int k = 0; k < 4; k++) begin
            Issueblk_Issue = 1'b1;
            tick();
        end
        check("drain_count", IssueQue_Count, 0);

        // younger ready entry bypasses a waiting older one; wakeup visible one cycle later
        disp(5'd10, 5'd7, 1'b0, 16'h0000, 5'd0, 1'b1, rt_of(5'd10));
        tick();
        disp(5'd11, 5'd0, 1'b1, rs_of(5'd11), 5'd0, 1'b1, rt_of(5'd11));
        tick();
        Issueblk_Issue = 1'b1;
        push(5'd11, rs_of(5'd11), rt_of(5'd11));
        tick();
        CDB_Valid = 1'b1; CDB_Tag = 5'd7; CDB_Data = 16'h1234;
        Issueblk_Issue = 1'b1;
        #1;
        check("wake_same_cycle_ready", IssueQue_Ready, 0);
        tick();
        check("wake_count", IssueQue_Count, 1);
        check("wake_ready", IssueQue_Ready, 1);
        check("wake_tag", IssueQue_Rd_Tag, 10);
        check("wake_rs_data", IssueQue_Rs_Data, 16'h1234);
        push(5'd10, 16'h1234, rt_of(5'd10));
        Issueblk_Issue = 1'b1;
        tick();

        // wakeup captured in the post-shift slot
        disp(5'd20, 5'd0, 1'b1, rs_of(5'd20), 5'd0, 1'b1, rt_of(5'd20));
        tick();
        disp(5'd21, 5'd3, 1'b0, 16'h0000, 5'd0, 1'b1, rt_of(5'd21));
        tick();
        disp(5'd22, 5'd0, 1'b1, rs_of(5'd22), 5'd8, 1'b0, 16'h0000);
        tick();
        Issueblk_Issue = 1'b1;
        CDB_Valid = 1'b1; CDB_Tag = 5'd8; CDB_Data = 16'h5A5A;
        push(5'd20, rs_of(5'd20), rt_of(5'd20));
        tick();
        check("shift_wake_count", IssueQue_Count, 2);
        check("shift_wake_ready", IssueQue_Ready, 1);
        check("shift_wake_tag", IssueQue_Rd_Tag, 22);
        check("shift_wake_rt", IssueQue_Rt_Data, 16'h5A5A);
        push(5'd22, rs_of(5'd22), 16'h5A5A);
        Issueblk_Issue = 1'b1;
        tick();
        CDB_Valid = 1'b1; CDB_Tag = 5'd3; CDB_Data = 16'h0303;
        tick();
        push(5'd21, 16'h0303, rt_of(5'd21));
        Issueblk_Issue = 1'b1;
        tick();
        check("shift_wake_drain", IssueQue_Count, 0);

        // dispatch coinciding with a matching broadcast
        disp(5'd12, 5'd0, 1'b1, rs_of(5'd12), 5'd9, 1'b0, 16'h1111);
        CDB_Valid = 1'b1; CDB_Tag = 5'd9; CDB_Data = 16'hBEEF;
        tick();
        check("bypass_count", IssueQue_Count, 1);
`ifdef ISSUEQ_DISPATCH_BYPASS_EN
        check("bypass_ready", IssueQue_Ready, 1);
        check("bypass_rt", IssueQue_Rt_Data, 16'hBEEF);
`else
        check("bypass_ready", IssueQue_Ready, 0);
`endif

        // flush beats a same-cycle dispatch
        disp(5'd13, 5'd0, 1'b1, rs_of(5'd13), 5'd0, 1'b1, rt_of(5'd13));
        RB_Flush_Valid = 1'b1;
        #1;
        check("flush_pre_count", IssueQue_Count, 1);
        tick();
        check("flush_count", IssueQue_Count, 0);
        check("flush_ready", IssueQue_Ready, 0);

        // asynchronous reset in the middle of a cycle
        disp(5'd14, 5'd0, 1'b1, rs_of(5'd14), 5'd0, 1'b1, rt_of(5'd14));
        tick();
        disp(5'd15, 5'd0, 1'b1, rs_of(5'd15), 5'd0, 1'b1, rt_of(5'd15));
        tick();
        check("pre_rst_count", IssueQue_Count, 2);
        check("pre_rst_ready", IssueQue_Ready, 1);
        #2 Rst = 1'b1;
        #1;
        check("async_rst_count", IssueQue_Count, 0);
        check("async_rst_ready", IssueQue_Ready, 0);
        check("async_rst_full", IssueQue_Full, 0);
        check("async_rst_tag", IssueQue_Rd_Tag, 0);
        check("async_rst_rs", IssueQue_Rs_Data, 0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check("post_rst_count", IssueQue_Count, 0);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
